// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller with double-buffered data, leading-zero
// blanking and a per-digit DP mask. Define SEG_DISPLAY_BCD_EN to build the binary-to-BCD converter.
module seg_display_ctrl #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [31:0]       wr_data,
    output logic [7:0]        seg_out,
    output logic [DIGITS-1:0] an_out,
    output logic              frame_done
);

    localparam int DATA_W = 4 * DIGITS;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W  = $clog2(SCAN_DIV);

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{SEG_ACTIVE_LOW}};

    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] active;
    logic              en;
    logic              lzb;
    logic [DIGITS-1:0] dp_mask;
    logic              pending;
    logic              dash;
    logic [PRE_W-1:0]  prescale;
    logic [IDX_W-1:0]  idx;

    logic              wr_data_sel;
    logic              wr_ctrl_sel;
    logic              tc;
    logic              boundary;
    logic              enable_xfer;
    logic              xfer_req;
    logic              busy;
    logic [DATA_W+31:0] wr_ext;
    logic              unused_bits;

    assign wr_ext      = {{DATA_W{1'b0}}, wr_data};
    assign wr_data_sel = wr_en && (wr_addr == 2'd0);
    assign wr_ctrl_sel = wr_en && (wr_addr == 2'd1);
    assign tc          = (prescale == PRE_LAST);
    assign boundary    = en && tc && (idx == IDX_LAST);
    // Data written while disabled is shown as soon as the display is switched on
    assign enable_xfer = wr_ctrl_sel && wr_data[0] && !en && pending;
    assign xfer_req    = (boundary || enable_xfer) && !busy;

`ifdef SEG_DISPLAY_BCD_EN
    logic              bcd;
    logic              xfer_bcd;
    logic [31:0]       bin_sr;
    logic [39:0]       bcd_sr;
    logic [39:0]       bcd_adj;
    logic [39:0]       bcd_final;
    logic [4:0]        bit_cnt;
    logic              ovf;
    logic [DATA_W+31:0] shadow_ext;
    logic [DATA_W+39:0] bcd_ext;

    assign xfer_bcd   = enable_xfer ? wr_data[2] : bcd;
    assign shadow_ext = {32'b0, shadow};
    assign bcd_ext    = {{DATA_W{1'b0}}, bcd_final};

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
    always_comb begin
        bcd_adj = '0;
        ovf     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bcd_adj[4*i +: 4] = (bcd_sr[4*i +: 4] >= 4'd5) ? bcd_sr[4*i +: 4] + 4'd3
                                                            : bcd_sr[4*i +: 4];
        end
        bcd_final = {bcd_adj[38:0], bin_sr[31]};
        for (int i = 0; i < 10; i++) begin
            if ((i >= DIGITS) && (bcd_final[4*i +: 4] != 4'h0)) begin
                ovf = 1'b1;
            end
        end
    end

    assign unused_bits = ^{wr_ext, shadow_ext, bcd_ext, bcd_adj[39]};
`else
    assign busy        = 1'b0;
    assign unused_bits = ^wr_ext;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow     <= '0;
            active     <= '0;
            en         <= 1'b0;
            lzb        <= 1'b0;
            dp_mask    <= '0;
            pending    <= 1'b0;
            dash       <= 1'b0;
            prescale   <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
`ifdef SEG_DISPLAY_BCD_EN
            bcd        <= 1'b0;
            busy       <= 1'b0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            bit_cnt    <= '0;
`endif
        end else begin
            if (wr_data_sel) begin
                shadow <= wr_ext[DATA_W-1:0];
                if (!en) begin
                    pending <= 1'b1;
                end
            end
            if (wr_ctrl_sel) begin
                en      <= wr_data[0];
                lzb     <= wr_data[1];
                dp_mask <= wr_ext[8 +: DIGITS];
`ifdef SEG_DISPLAY_BCD_EN
                bcd     <= wr_data[2];
`endif
            end

            if (en) begin
                prescale <= tc ? '0 : prescale + PRE_W'(1);
                if (tc) begin
                    idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end else begin
                prescale <= '0;
                idx      <= '0;
            end

            frame_done <= boundary;

            // Transfers read the registered shadow, so a same-cycle write waits one frame
            if (xfer_req) begin
                pending <= 1'b0;
`ifdef SEG_DISPLAY_BCD_EN
                if (xfer_bcd) begin
                    bin_sr  <= shadow_ext[31:0];
                    bcd_sr  <= '0;
                    bit_cnt <= '0;
                    busy    <= 1'b1;
                end else begin
                    active <= shadow;
                    dash   <= 1'b0;
                end
`else
                active <= shadow;
                dash   <= 1'b0;
`endif
            end

`ifdef SEG_DISPLAY_BCD_EN
            if (busy) begin
                bin_sr  <= {bin_sr[30:0], 1'b0};
                bcd_sr  <= bcd_final;
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd31) begin
                    busy   <= 1'b0;
                    active <= bcd_ext[DATA_W-1:0];
                    dash   <= ovf;
                end
            end
`endif
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [3:0]        cur_nib;
    logic [IDX_W-1:0]  msd;
    logic              blank;
    logic [6:0]        segs;
    logic [7:0]        seg_hi;
    logic [DIGITS-1:0] an_hi;

    // msd is the highest nonzero nibble; it stays 0 for an all-zero value so digit 0 shows
    always_comb begin
        cur_nib = 4'h0;
        msd     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (active[4*i +: 4] != 4'h0) begin
                msd = IDX_W'(i);
            end
            if (IDX_W'(i) == idx) begin
                cur_nib = active[4*i +: 4];
            end
        end
        blank  = lzb && !dash && (idx > msd);
        segs   = dash ? 7'h40 : (blank ? 7'h00 : hex7(cur_nib));
        seg_hi = {dp_mask[idx], segs};
        an_hi  = DIGITS'(1) << idx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_out <= SEG_OFF;
            an_out  <= AN_OFF;
        end else if (!en) begin
            seg_out <= SEG_OFF;
            an_out  <= AN_OFF;
        end else begin
            seg_out <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            an_out  <= SEG_ACTIVE_LOW ? ~an_hi : an_hi;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl (DIGITS=8, SCAN_DIV=4, active-low outputs).
// The BCD section runs only when SEG_DISPLAY_BCD_EN is defined.
module tb_seg_display_ctrl;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic [7:0]  seg_out;
    logic [7:0]  an_out;
    logic        frame_done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;
    int fd_cycle     = 0;
    int prev_fd      = 0;

    logic [7:0] exp_seg [DIGITS];

    seg_display_ctrl #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .seg_out(seg_out),
        .an_out(an_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One-cycle register write, issued from a falling edge
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 32'd0;
    endtask

    task automatic syncFrame(input string tag);
        int waited;
        waited = 0;
        step(1);
        while (frame_done !== 1'b1 && waited < 4 * FRAME) begin
            step(1);
            waited++;
        end
        checkOutput({tag, "_frame_done"}, {31'd0, frame_done}, 32'd1);
        prev_fd  = fd_cycle;
        fd_cycle = cycle;
    endtask

    // Called on the falling edge where frame_done is high; walks digits 0..7
    task automatic showDigits(input string tag);
        logic [7:0] exp_an;
        for (int k = 0; k < DIGITS; k++) begin
            step((k == 0) ? 1 : SCAN_DIV);
            if (k == 0) begin
                checkOutput({tag, "_fd_pulse"}, {31'd0, frame_done}, 32'd0);
            end
            exp_an = ~(8'h01 << k);
            checkOutput($sformatf("%s_seg%0d", tag, k), {24'd0, seg_out}, {24'd0, exp_seg[k]});
            checkOutput($sformatf("%s_an%0d", tag, k), {24'd0, an_out}, {24'd0, exp_an});
        end
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_an", {24'd0, an_out}, 32'hFF);
        checkOutput("rst_seg", {24'd0, seg_out}, 32'hFF);
        checkOutput("rst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b1;
        step(1);

        // Hex display, data written while enabled shows after the first frame
        applyStimulus(2'd1, 32'h0000_0001);
        applyStimulus(2'd0, 32'h1234_ABCD);
        syncFrame("hex_first");
        exp_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        showDigits("hex");
        syncFrame("hex_next");
        checkOutput("frame_period", fd_cycle - prev_fd, FRAME);

        // Reset held mid-scan wipes outputs and control
        step(5);
        rst = 1'b0;
        step(3);
        checkOutput("midrst_an", {24'd0, an_out}, 32'hFF);
        checkOutput("midrst_seg", {24'd0, seg_out}, 32'hFF);
        checkOutput("midrst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b1;
        step(6);
        checkOutput("postrst_an", {24'd0, an_out}, 32'hFF);
        checkOutput("postrst_seg", {24'd0, seg_out}, 32'hFF);

        // Leading-zero blanking; data written while disabled appears immediately
        applyStimulus(2'd0, 32'h0000_00A5);
        applyStimulus(2'd1, 32'h0000_0003);
        step(1);
        checkOutput("lzb_immediate_seg", {24'd0, seg_out}, 32'h92);
        checkOutput("lzb_immediate_an", {24'd0, an_out}, 32'hFE);
        syncFrame("lzb");
        exp_seg = '{8'h92, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        showDigits("lzb_a5");
        applyStimulus(2'd0, 32'h0000_0000);
        syncFrame("lzb_zero");
        exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        showDigits("lzb_zero");

        // Write landing on the frame-boundary edge is deferred by one frame
        applyStimulus(2'd1, 32'h0000_0001);
        applyStimulus(2'd0, 32'h8765_4321);
        syncFrame("bnd_load");
        step(FRAME - 1);
        applyStimulus(2'd0, 32'h0000_00F0);
        checkOutput("bnd_same_edge_fd", {31'd0, frame_done}, 32'd1);
        exp_seg = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
        showDigits("bnd_old");
        syncFrame("bnd_new");
        exp_seg = '{8'hC0, 8'h8E, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        showDigits("bnd_new");

        // DP mask on digits 0 and 2
        applyStimulus(2'd1, 32'h0000_0501);
        syncFrame("dp");
        exp_seg = '{8'h40, 8'h8E, 8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        showDigits("dp");

        // Disable mid-frame, then re-enable: scan restarts at digit 0
        step(10);
        applyStimulus(2'd1, 32'h0000_0000);
        step(1);
        checkOutput("dis_an", {24'd0, an_out}, 32'hFF);
        checkOutput("dis_seg", {24'd0, seg_out}, 32'hFF);
        checkOutput("dis_fd", {31'd0, frame_done}, 32'd0);
        applyStimulus(2'd1, 32'h0000_0001);
        step(1);
        checkOutput("reen_an_first", {24'd0, an_out}, 32'hFE);
        checkOutput("reen_seg_first", {24'd0, seg_out}, 32'hC0);
        step(SCAN_DIV - 1);
        checkOutput("reen_an_last", {24'd0, an_out}, 32'hFE);
        step(1);
        checkOutput("reen_an_next", {24'd0, an_out}, 32'hFD);

`ifdef SEG_DISPLAY_BCD_EN
        // BCD conversion and overflow dash
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        applyStimulus(2'd1, 32'h0000_0005);
        applyStimulus(2'd0, 32'd12345678);
        syncFrame("bcd_start");
        step(1);
        checkOutput("bcd_hold_seg", {24'd0, seg_out}, 32'hC0);
        syncFrame("bcd_done");
        exp_seg = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        showDigits("bcd");
        applyStimulus(2'd0, 32'd100000000);
        syncFrame("bcd_ovf_start");
        syncFrame("bcd_ovf_done");
        exp_seg = '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
        showDigits("bcd_ovf");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
